// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Hits complete combinationally in IDLE; misses refill a whole line from backing memory.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int AW    = IDX_W + OFF_W;
  localparam int TAG_W = 30 - AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [31:0]      data_arr_r [0:LINES*WORDS-1];
  logic [TAG_W-1:0] tag_arr_r  [0:LINES-1];
  logic [LINES-1:0] valid_r;
  logic [OFF_W-1:0] cnt_r;
  logic [OFF_W-1:0] cnt_next_s;

  logic [OFF_W-1:0] offset_s;
  logic [IDX_W-1:0] index_s;
  logic [TAG_W-1:0] tag_s;
  logic             line_hit_s;
  logic [31:0]      rd_word_s;
  logic             hit_s;
  logic             refill_we_s;
  logic             store_we_s;
  logic             fill_done_s;
  logic             mem_req_next_s;
  logic             mem_we_next_s;
  logic [31:0]      mem_addr_next_s;
  logic [31:0]      mem_wdata_next_s;

  assign offset_s   = address[OFF_W+1:2];
  assign index_s    = address[AW+1:OFF_W+2];
  assign tag_s      = address[31:AW+2];
  assign line_hit_s = valid_r[index_s] && (tag_arr_r[index_s] == tag_s);
  assign rd_word_s  = data_arr_r[{index_s, offset_s}];

  // Reset forces the pipeline-facing outputs to "no stall, zero data".
  assign hit      = (!RST_N) | hit_s;
  assign readData = RST_N ? rd_word_s : 32'd0;

  // Next-state, word counter and array write-enable decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    hit_s        = 1'b0;
    refill_we_s  = 1'b0;
    store_we_s   = 1'b0;
    fill_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (memWrite) begin
          state_next_s = WRITE;
        end else if (memRead) begin
          if (line_hit_s) begin
            hit_s = 1'b1;
          end else begin
            cnt_next_s   = '0;
            state_next_s = REFILL;
          end
        end else begin
          hit_s = 1'b1;
        end
      end
      REFILL: begin
        if (memReady) begin
          refill_we_s = 1'b1;
          cnt_next_s  = cnt_r + OFF_W'(1);
          if (cnt_r == OFF_W'(WORDS - 1)) begin
            fill_done_s  = 1'b1;
            state_next_s = DONE;
          end else begin
            state_next_s = REFILL;
          end
        end else begin
          state_next_s = REFILL;
        end
      end
      WRITE: begin
        if (memReady) begin
          // No-write-allocate: only a resident line absorbs the store.
          store_we_s   = line_hit_s;
          state_next_s = DONE;
        end else begin
          state_next_s = WRITE;
        end
      end
      DONE: begin
        hit_s        = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Memory-side outputs are computed from the next state so they are registered
  // yet already valid in the first REFILL/WRITE cycle.
  always_comb begin
    mem_req_next_s   = (state_next_s == REFILL) || (state_next_s == WRITE);
    mem_we_next_s    = (state_next_s == WRITE);
    mem_addr_next_s  = memAddr;
    mem_wdata_next_s = memWData;
    case (state_next_s)
      REFILL: begin
        mem_addr_next_s = {tag_s, index_s, cnt_next_s, 2'b00};
      end
      WRITE: begin
        mem_addr_next_s  = address & 32'hFFFF_FFFC;
        mem_wdata_next_s = writeData;
      end
      default: begin
        mem_addr_next_s  = memAddr;
        mem_wdata_next_s = memWData;
      end
    endcase
  end

  // State, refill counter and valid bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      valid_r <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (fill_done_s) begin
        valid_r[index_s] <= 1'b1;
      end
    end
  end

  // Registered backing-memory interface.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= 32'd0;
      memWData <= 32'd0;
    end else begin
      memReq   <= mem_req_next_s;
      memWe    <= mem_we_next_s;
      memAddr  <= mem_addr_next_s;
      memWData <= mem_wdata_next_s;
    end
  end

  // Data and tag arrays; contents are only trusted behind a valid bit.
  always_ff @(posedge CLK) begin
    if (refill_we_s) begin
      data_arr_r[{index_s, cnt_r}] <= memRData;
    end else if (store_we_s) begin
      data_arr_r[{index_s, offset_s}] <= writeData;
    end
    if (fill_done_s) begin
      tag_arr_r[index_s] <= tag_s;
    end
  end

endmodule
